scarv_cop_malu_mc: RTL and testbench

- Parametrised multi-cycle multi-precision ALU for the SCARV crypto coprocessor, the next generation of the MALU slot in the execute stage.
- Performs 3-input add/sub with carry/borrow, double-word shifts, and an iterative multiply/multiply-accumulate producing a 2*XLEN result.
- Results go back as a lo/hi register pair with per-word write enables.

---
 rtl/scarv_cop_malu_mc.sv | 169 ++++++++++++++++
 tb/tb_scarv_cop_malu_mc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scarv_cop_malu_mc.sv
// Multi-cycle multi-precision ALU for the SCARV coprocessor MALU slot.
// Single-cycle 3-input add/sub and double-word shifts, plus an iterative
// shift-add multiply / multiply-accumulate producing a 2*XLEN result that
// is returned as a lo/hi register pair.
module scarv_cop_malu_mc #(
  parameter int         XLEN       = 32,
  parameter int         MUL_BITS   = 1,
  parameter logic [2:0] CLASS_MALU = 3'd3
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            malu_ivalid,
  output logic            malu_idone,
  output logic            malu_busy,
  input  logic [XLEN-1:0] malu_rs1,
  input  logic [XLEN-1:0] malu_rs2,
  input  logic [XLEN-1:0] malu_rs3,
  input  logic [31:0]     id_imm,
  input  logic [2:0]      id_class,
  input  logic [3:0]      id_subclass,
  output logic [1:0]      malu_rd_wen,
  output logic [XLEN-1:0] malu_rd_wdata_lo,
  output logic [XLEN-1:0] malu_rd_wdata_hi
);

  localparam int NSTEP = XLEN / MUL_BITS;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int SHW   = $clog2(2 * XLEN);
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              accept;
  logic              is_mul_op;
  logic              mul_last;
  logic [2*XLEN-1:0] acc_step;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     diff;
  logic [SHW-1:0]    sh;
  logic [2*XLEN-1:0] cat;
  logic [2*XLEN-1:0] single_res;
  logic [1:0]        single_wen;

  logic              unused_imm;

  // One shift-add step: the multiplicand times the next multiplier digit,
  // placed at the digit's weight within the double-width product.
  function automatic logic [2*XLEN-1:0] partial(
    input logic [XLEN-1:0]     a,
    input logic [MUL_BITS-1:0] d,
    input logic [CW-1:0]       c
  );
    logic [2*XLEN-1:0] p;
    p = {{XLEN{1'b0}}, a} * {{(2*XLEN-MUL_BITS){1'b0}}, d};
    return p << (int'(c) * MUL_BITS);
  endfunction

  assign accept    = (state == IDLE) && malu_ivalid && (id_class == CLASS_MALU);
  assign is_mul_op = (id_subclass == 4'd4) || (id_subclass == 4'd5);
  assign mul_last  = (state == MUL) && (cnt == LAST);
  assign acc_step  = acc + partial(mcand, mplier[MUL_BITS-1:0], cnt);

  // Only the shift amount bits of the immediate matter.
  assign unused_imm = ^id_imm[31:SHW];

  // Single-cycle results, computed from the operands on the accept edge.
  always_comb begin
    sum        = {1'b0, malu_rs1} + {1'b0, malu_rs2} + {{XLEN{1'b0}}, malu_rs3[0]};
    diff       = {1'b0, malu_rs1} - {1'b0, malu_rs2} - {{XLEN{1'b0}}, malu_rs3[0]};
    sh         = id_imm[SHW-1:0];
    cat        = {malu_rs1, malu_rs2};
    single_res = '0;
    single_wen = 2'b00;
    case (id_subclass)
      4'd0: begin
        single_res = {{(XLEN-1){1'b0}}, sum};
        single_wen = 2'b11;
      end
      4'd1: begin
        single_res = {{(XLEN-1){1'b0}}, diff};
        single_wen = 2'b11;
      end
      4'd2: begin
        single_res = cat << sh;
        single_wen = 2'b11;
      end
      4'd3: begin
        single_res = cat >> sh;
        single_wen = 2'b11;
      end
      default: begin
        single_res = '0;
        single_wen = 2'b00;
      end
    endcase
  end

  // State register.
  always_ff @(posedge g_clk) begin
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul_op ? MUL : DONE;
      MUL:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    malu_idone = (state == DONE);
    malu_busy  = (state != IDLE);
  end

  // Operand capture and the iterative multiplier accumulator / digit counter.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= malu_rs1;
      mplier <= malu_rs2;
      acc    <= (id_subclass == 4'd4) ? {{XLEN{1'b0}}, malu_rs3} : '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_step;
      mplier <= mplier >> MUL_BITS;
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Writeback registers: loaded only on the edge into DONE, zero otherwise.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      malu_rd_wen      <= 2'b00;
      malu_rd_wdata_lo <= '0;
      malu_rd_wdata_hi <= '0;
    end else if (accept && !is_mul_op) begin
      malu_rd_wen      <= single_wen;
      malu_rd_wdata_lo <= single_res[XLEN-1:0];
      malu_rd_wdata_hi <= single_res[2*XLEN-1:XLEN];
    end else if (mul_last) begin
      malu_rd_wen      <= 2'b11;
      malu_rd_wdata_lo <= acc_step[XLEN-1:0];
      malu_rd_wdata_hi <= acc_step[2*XLEN-1:XLEN];
    end else begin
      malu_rd_wen      <= 2'b00;
      malu_rd_wdata_lo <= '0;
      malu_rd_wdata_hi <= '0;
    end
  end

endmodule

// File: tb/tb_scarv_cop_malu_mc.sv
// Directed bench for scarv_cop_malu_mc: one instance at MUL_BITS=1 and one
// at MUL_BITS=4, sharing operand inputs but with separate ivalid strobes.
module tb_scarv_cop_malu_mc;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        ivalid, ivalid4;
  logic [31:0] rs1, rs2, rs3, imm;
  logic [2:0]  cls;
  logic [3:0]  sub;

  logic        done1, busy1, done4, busy4;
  logic [1:0]  wen1, wen4;
  logic [31:0] lo1, hi1, lo4, hi4;

  logic        sel4;
  logic        o_done, o_busy;
  logic [1:0]  o_wen;
  logic [31:0] o_lo, o_hi;

  int checks   = 0;
  int failures = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_malu_mc #(.XLEN(32), .MUL_BITS(1), .CLASS_MALU(3'd3)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .malu_ivalid(ivalid),
    .malu_idone(done1), .malu_busy(busy1),
    .malu_rs1(rs1), .malu_rs2(rs2), .malu_rs3(rs3), .id_imm(imm),
    .id_class(cls), .id_subclass(sub), .malu_rd_wen(wen1),
    .malu_rd_wdata_lo(lo1), .malu_rd_wdata_hi(hi1)
  );

  scarv_cop_malu_mc #(.XLEN(32), .MUL_BITS(4), .CLASS_MALU(3'd3)) dut4 (
    .g_clk(g_clk), .g_reset(g_reset), .malu_ivalid(ivalid4),
    .malu_idone(done4), .malu_busy(busy4),
    .malu_rs1(rs1), .malu_rs2(rs2), .malu_rs3(rs3), .id_imm(imm),
    .id_class(cls), .id_subclass(sub), .malu_rd_wen(wen4),
    .malu_rd_wdata_lo(lo4), .malu_rd_wdata_hi(hi4)
  );

  assign o_done = sel4 ? done4 : done1;
  assign o_busy = sel4 ? busy4 : busy1;
  assign o_wen  = sel4 ? wen4  : wen1;
  assign o_lo   = sel4 ? lo4   : lo1;
  assign o_hi   = sel4 ? hi4   : hi1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one instruction and wait (bounded) for idone. Returns the cycle
  // of idone relative to the accept cycle, and the count of busy cycles
  // seen before it. ivalid drops at idone, or earlier at cycle drop_at.
  task automatic do_op(input bit s4, input logic [3:0] sb, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c, input logic [31:0] im,
                       input int drop_at, output int cyc, output int busyn);
    @(negedge g_clk);
    sel4 = s4;
    cls = 3'd3; sub = sb; rs1 = a; rs2 = b; rs3 = c; imm = im;
    if (s4) ivalid4 = 1'b1; else ivalid = 1'b1;
    cyc = 0; busyn = 0;
    while (cyc < 100) begin
      @(negedge g_clk);
      cyc++;
      if (o_done) break;
      if (o_busy) busyn++;
      if (cyc == drop_at) begin ivalid = 1'b0; ivalid4 = 1'b0; end
    end
    ivalid = 1'b0; ivalid4 = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] sb, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c, input logic [31:0] im,
                        input logic [1:0] ewen, input logic [31:0] elo, input logic [31:0] ehi);
    int cyc, bn;
    do_op(1'b0, sb, a, b, c, im, 0, cyc, bn);
    check({tag, "_cyc"}, 64'(cyc), 64'd1);
    check({tag, "_wen"}, 64'(o_wen), 64'(ewen));
    check({tag, "_lo"},  64'(o_lo),  64'(elo));
    check({tag, "_hi"},  64'(o_hi),  64'(ehi));
  endtask

  initial begin
    int cyc, bn, seen, bseen;
    sel4 = 1'b0;
    g_reset = 1'b1; ivalid = 1'b0; ivalid4 = 1'b0;
    rs1 = '0; rs2 = '0; rs3 = '0; imm = '0; cls = '0; sub = '0;
    repeat (3) @(negedge g_clk);
    check("rst_idone", 64'(done1), 64'd0);
    check("rst_busy",  64'(busy1), 64'd0);
    check("rst_wen",   64'(wen1),  64'd0);
    check("rst_lo",    64'(lo1),   64'd0);
    check("rst_hi",    64'(hi1),   64'd0);
    g_reset = 1'b0;

    single("add3",    4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h1, 32'h0, 2'b11, 32'h00000001, 32'h1);
    single("add3max", 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h0, 2'b11, 32'hFFFFFFFF, 32'h1);
    single("add3c0",  4'd0, 32'h00000010, 32'h00000020, 32'h2, 32'h0, 2'b11, 32'h00000030, 32'h0);
    // Output must return to zero the cycle after DONE.
    @(negedge g_clk);
    check("post_wen", 64'(wen1), 64'd0);
    check("post_lo",  64'(lo1),  64'd0);
    single("sub3a",   4'd1, 32'h0, 32'h1, 32'h0, 32'h0, 2'b11, 32'hFFFFFFFF, 32'h1);
    single("sub3b",   4'd1, 32'h5, 32'h3, 32'h1, 32'h0, 2'b11, 32'h00000001, 32'h0);
    single("sll2",    4'd2, 32'h0, 32'h80000001, 32'h0, 32'd1,  2'b11, 32'h00000002, 32'h1);
    single("sll2sh0", 4'd2, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'd0, 2'b11, 32'h9ABCDEF0, 32'h12345678);
    single("srl2m64", 4'd3, 32'h0, 32'h80000001, 32'h0, 32'd64, 2'b11, 32'h80000001, 32'h0);
    single("srl2s63", 4'd3, 32'h0, 32'h80000001, 32'h0, 32'd63, 2'b11, 32'h0, 32'h0);
    single("srl2s36", 4'd3, 32'hF0000000, 32'h0, 32'h0, 32'd36, 2'b11, 32'h0F000000, 32'h0);
    single("illegal", 4'd9, 32'h12345678, 32'h1, 32'h1, 32'h0, 2'b00, 32'h0, 32'h0);

    // MAC, one bit per cycle.
    do_op(1'b0, 4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, cyc, bn);
    check("mac1_cyc",  64'(cyc), 64'd33);
    check("mac1_busy", 64'(bn),  64'd32);
    check("mac1_wen",  64'(o_wen), 64'd3);
    check("mac1_lo",   64'(o_lo), 64'h0);
    check("mac1_hi",   64'(o_hi), 64'hFFFFFFFF);

    // MUL ignores rs3.
    do_op(1'b0, 4'd5, 32'h7, 32'h6, 32'h5, 32'h0, 0, cyc, bn);
    check("mul1_cyc", 64'(cyc), 64'd33);
    check("mul1_lo",  64'(o_lo), 64'h2A);
    check("mul1_hi",  64'(o_hi), 64'h0);

    // MAC, four bits per cycle.
    do_op(1'b1, 4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, cyc, bn);
    check("mac4_cyc",  64'(cyc), 64'd9);
    check("mac4_busy", 64'(bn),  64'd8);
    check("mac4_lo",   64'(o_lo), 64'h0);
    check("mac4_hi",   64'(o_hi), 64'hFFFFFFFF);

    // MUL with ivalid dropped at cycle 3 still completes.
    do_op(1'b1, 4'd5, 32'hFFFFFFFF, 32'h2, 32'h0, 32'h0, 3, cyc, bn);
    check("mul4drop_cyc", 64'(cyc), 64'd9);
    check("mul4drop_lo",  64'(o_lo), 64'hFFFFFFFE);
    check("mul4drop_hi",  64'(o_hi), 64'h1);
    do_op(1'b1, 4'd5, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 0, cyc, bn);
    check("mul4big_lo", 64'(o_lo), 64'h0);
    check("mul4big_hi", 64'(o_hi), 64'h1);
    sel4 = 1'b0;

    // Reset asserted in MUL cycle 10 abandons the instruction.
    @(negedge g_clk);
    cls = 3'd3; sub = 4'd4; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF; rs3 = 32'h1;
    ivalid = 1'b1;
    repeat (10) @(negedge g_clk);
    check("rst_mid_busy_before", 64'(busy1), 64'd1);
    g_reset = 1'b1; ivalid = 1'b0;
    @(negedge g_clk);
    g_reset = 1'b0;
    check("rst_mid_busy", 64'(busy1), 64'd0);
    check("rst_mid_wen",  64'(wen1),  64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge g_clk);
      if (done1 || wen1 != 2'b00) seen++;
    end
    check("rst_mid_noidone", 64'(seen), 64'd0);
    single("add3_after_rst", 4'd0, 32'h00000003, 32'h00000004, 32'h1, 32'h0, 2'b11, 32'h8, 32'h0);

    // Wrong class is ignored entirely.
    @(negedge g_clk);
    cls = 3'd1; sub = 4'd0; ivalid = 1'b1;
    seen = 0; bseen = 0;
    repeat (6) begin
      @(negedge g_clk);
      if (done1) seen++;
      if (busy1) bseen++;
    end
    ivalid = 1'b0;
    check("badclass_idone", 64'(seen),  64'd0);
    check("badclass_busy",  64'(bseen), 64'd0);

    // Back-to-back ADD3: ivalid held through DONE, second accepted next cycle.
    @(negedge g_clk);
    cls = 3'd3; sub = 4'd0; rs1 = 32'h1; rs2 = 32'h2; rs3 = 32'h0; ivalid = 1'b1;
    @(negedge g_clk);
    check("b2b_first_done", 64'(done1), 64'd1);
    check("b2b_first_lo",   64'(lo1),   64'h3);
    @(negedge g_clk);
    check("b2b_gap_done", 64'(done1), 64'd0);
    check("b2b_gap_busy", 64'(busy1), 64'd0);
    rs1 = 32'd10; rs2 = 32'd20; rs3 = 32'h1;
    @(negedge g_clk);
    ivalid = 1'b0;
    check("b2b_second_done", 64'(done1), 64'd1);
    check("b2b_second_lo",   64'(lo1),   64'h1F);
    check("b2b_second_hi",   64'(hi1),   64'h0);
    @(negedge g_clk);
    check("b2b_after_done", 64'(done1), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
